mem_stage_dmem: RTL and testbench
=================================

# mem_stage_dmem

Data-memory stage of the five-stage MIPS pipeline, sitting between EX/MEM and MEM/WB and producing the `ReadData_MEM` word that MEM/WB latches. It supports byte, half and word loads and stores, with sign or zero extension on loads. Stores go through a one-entry write buffer that commits to the array one cycle later. Loads forward from that buffer so the pipeline never stalls.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; must be a power of two.
- `Clk`  in  1: rising-edge clock.
- `Reset`  in  1: asynchronous, active-low reset.
- `ALUResult_MEM`  in  32: byte address.
- `WriteData_MEM`  in  32: store data, right-justified.
- `MemRead_MEM`  in  1: load request.
- `MemWrite_MEM`  in  1: store request.
- `MemSize_MEM`  in  2: access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- `MemSigned_MEM`  in  1: sign-extend on load when 1, zero-extend when 0.
- `ReadData_MEM`  out  32: extended load result, combinational.
- `Misalign_MEM`  out  1: current access is misaligned, combinational.
- `MisalignSticky`  out  1: registered flag, set by any misaligned access.

## Operation
- **Addressing.**
  - Word index = `ALUResult_MEM[log2(DEPTH_WORDS)+1:2]`; upper address bits are ignored, so addresses wrap modulo the array size.
  - Byte offset `off` = `ALUResult_MEM[1:0]`.
  - Byte order is little-endian: byte `off` occupies bits [8·off+7 : 8·off].
- **Write buffer state:** `wb_valid`, `wb_idx`, `wb_data[31:0]` (lane-aligned) and `wb_be[3:0]`.
- **Store acceptance.** A store is accepted when `MemWrite_MEM`=1 and the access is not suppressed (see Configuration). Lane data and byte enables:
  - byte: data replicated into lane `off`, be = 1<<off.
  - half: be = 0011 when off[1]=0, 1100 when off[1]=1.
  - word: be = 1111.
- **Each rising edge:**
  - If `wb_valid`=1, write `wb_data` into `array[wb_idx]`, only the lanes enabled by `wb_be`.
  - If a store is accepted this cycle, load the buffer with it (`wb_valid`=1); otherwise clear `wb_valid`.
  - Commit of the old entry and capture of a new one happen on the same edge, including when both target the same index.
- **Loads.**
  - Raw word = `array[idx]`; each byte lane with `wb_be`=1 is replaced from `wb_data` when `wb_valid`=1 and `wb_idx`=idx.
  - The selected lane(s) are right-justified, then extended according to `MemSigned_MEM`.
  - Word loads ignore `MemSigned_MEM`.
- **Output gating.**
  - `ReadData_MEM` = 0 when `MemRead_MEM`=0.
  - When `MemRead_MEM` and `MemWrite_MEM` are both 1, the access is a store and `ReadData_MEM` = 0.
- **Misaligned access:** half with off[0]=1, or word with off≠00.
- **`MisalignSticky`:** set at the edge that follows any misaligned access with `MemRead_MEM` or `MemWrite_MEM` asserted; cleared only by reset.

## Timing
- **Load latency:** zero cycles; `ReadData_MEM` is combinational from the address, control inputs, array and buffer.
- **Store visibility:** a store accepted in cycle N is visible to loads from cycle N+1 (via buffer forwarding) and is resident in the array after edge N+1.
- **Same-cycle load of a just-issued store:** a load in cycle N to the address being stored in cycle N returns the pre-store data.
- **Back-to-back stores:** to the same word, the later store's lanes overwrite the earlier store's lanes in order. No cycle is lost and there is no stall.
- **Reset asserted** (Reset=0), asynchronously:
  - `wb_valid`=0 and `MisalignSticky`=0;
  - a pending buffered store is discarded;
  - array contents are not reset.
- **Outputs during reset:** `ReadData_MEM` and `Misalign_MEM` keep their combinational definitions.
- **Reset release:** normal operation starts at the first rising edge after Reset returns to 1.

## Configuration
- **Macro:** `DMEM_MISALIGN_TRAP_EN`.
- **Defined:**
  - misaligned accesses are suppressed: the store is not accepted and `ReadData_MEM` = 0;
  - `Misalign_MEM` flags the access;
  - `MisalignSticky` sets.
- **Undefined:**
  - addresses are force-aligned: half ignores bit 0, word ignores bits [1:0];
  - the access proceeds normally;
  - `Misalign_MEM` and `MisalignSticky` are tied to 0.

## Test plan
- **Word store, then loads:** sw 0xDEADBEEF to 0x10 in cycle N.
  - lw 0x10 in cycle N returns the old value 0.
  - lw 0x10 in cycles N+1 and N+2 returns 0xDEADBEEF.
- **Byte and half extension:** after the store above:
  - lb 0x13 → 0xFFFFFFDE;
  - lbu 0x13 → 0x000000DE;
  - lh 0x10 → 0xFFFFBEEF;
  - lhu 0x12 → 0x0000DEAD.
- **Back-to-back merge:** sb 0x11 data 0x55 then sh 0x12 data 0x1234 on consecutive cycles over a word holding 0 → next-cycle lw 0x10 = 0x12345500.
- **Wrap-around:** with DEPTH_WORDS=1024, sw 0xA5A5A5A5 to 0x1000 → lw 0x0 = 0xA5A5A5A5.
- **Reset mid-operation:** sw 0xCAFEF00D to 0x20, then Reset=0 before the next edge → lw 0x20 after release returns the prior contents (buffer discarded); `MisalignSticky`=0.
- **Misalignment, `DMEM_MISALIGN_TRAP_EN` defined:** lw 0x22 → `Misalign_MEM`=1, `ReadData_MEM`=0, `MisalignSticky`=1 at the next edge; sw 0x22 leaves memory unchanged.
  - With the macro undefined, lw 0x22 reads word 0x20 and both flags stay 0.

Source files
------------

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory: byte/half/word loads and stores through a one-entry write buffer.
// Optional macro DMEM_MISALIGN_TRAP_EN suppresses misaligned accesses and flags them.
module mem_stage_dmem #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] ALUResult_MEM,
    input  logic [31:0] WriteData_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [1:0]  MemSize_MEM,
    input  logic        MemSigned_MEM,
    output logic [31:0] ReadData_MEM,
    output logic        Misalign_MEM,
    output logic        MisalignSticky
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic             wb_valid_q, wb_valid_d;
    logic [IDX_W-1:0] wb_idx_q, wb_idx_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [3:0]       wb_be_q, wb_be_d;
    logic             sticky_q, sticky_d;

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             isByte, isHalf, misalign, suppress, storeAcc;
    logic [31:0]      stData, merged, shifted, loadVal;
    logic [3:0]       stBe;
    logic             unused_bits;

    assign idx    = ALUResult_MEM[IDX_W+1:2];
    assign off    = ALUResult_MEM[1:0];
    assign isByte = (MemSize_MEM == 2'b00);
    assign isHalf = (MemSize_MEM == 2'b01);
    assign misalign = (isHalf && off[0]) || (MemSize_MEM[1] && (off != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign suppress     = misalign;
    assign Misalign_MEM = misalign;
    assign sticky_d     = sticky_q | (misalign & (MemRead_MEM | MemWrite_MEM));
    assign unused_bits  = ^ALUResult_MEM[31:IDX_W+2];
`else
    assign suppress     = 1'b0;
    assign Misalign_MEM = 1'b0;
    assign sticky_d     = 1'b0;
    assign unused_bits  = ^{ALUResult_MEM[31:IDX_W+2], misalign, sticky_q};
`endif

    assign MisalignSticky = sticky_q;
    assign storeAcc       = MemWrite_MEM && !suppress;

    always_comb begin
        stData = WriteData_MEM;
        stBe   = 4'b1111;
        if (isByte) begin
            stData = {4{WriteData_MEM[7:0]}};
            stBe   = 4'b0001 << off;
        end else if (isHalf) begin
            stData = {2{WriteData_MEM[15:0]}};
            stBe   = off[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_comb begin
        wb_valid_d = storeAcc;
        wb_idx_d   = wb_idx_q;
        wb_data_d  = wb_data_q;
        wb_be_d    = wb_be_q;
        if (storeAcc) begin
            wb_idx_d  = idx;
            wb_data_d = stData;
            wb_be_d   = stBe;
        end
    end

    // A pending buffered store overrides the array lane by lane for the same word.
    always_comb begin
        merged = mem_q[idx];
        for (int i = 0; i < 4; i++) begin
            if (wb_valid_q && (wb_idx_q == idx) && wb_be_q[i]) begin
                merged[8*i +: 8] = wb_data_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        shifted = merged >> {off, 3'b000};
        loadVal = merged;
        if (isByte) begin
            loadVal = MemSigned_MEM ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
        end else if (isHalf) begin
            if (off[1]) begin
                loadVal = MemSigned_MEM ? {{16{merged[31]}}, merged[31:16]} : {16'b0, merged[31:16]};
            end else begin
                loadVal = MemSigned_MEM ? {{16{merged[15]}}, merged[15:0]} : {16'b0, merged[15:0]};
            end
        end
    end

    assign ReadData_MEM = (MemRead_MEM && !MemWrite_MEM && !suppress) ? loadVal : 32'b0;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wb_valid_q <= 1'b0;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
            wb_be_q    <= '0;
            sticky_q   <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_idx_q   <= wb_idx_d;
            wb_data_q  <= wb_data_d;
            wb_be_q    <= wb_be_d;
            sticky_q   <= sticky_d;
        end
    end

    // The array itself is never reset; reset only kills the pending commit via wb_valid_q.
    always_ff @(posedge Clk) begin
        if (wb_valid_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_be_q[i]) begin
                    mem_q[wb_idx_q][8*i +: 8] <= wb_data_q[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed testbench for mem_stage_dmem with hand-computed expected values.
// Honours DMEM_MISALIGN_TRAP_EN when the same define is given to the build.
module tb_mem_stage_dmem;
    logic        Clk;
    logic        Reset;
    logic [31:0] ALUResult_MEM;
    logic [31:0] WriteData_MEM;
    logic        MemRead_MEM;
    logic        MemWrite_MEM;
    logic [1:0]  MemSize_MEM;
    logic        MemSigned_MEM;
    logic [31:0] ReadData_MEM;
    logic        Misalign_MEM;
    logic        MisalignSticky;

    int vectorCount = 0;
    int missCount   = 0;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    mem_stage_dmem #(.DEPTH_WORDS(1024)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .ALUResult_MEM(ALUResult_MEM),
        .WriteData_MEM(WriteData_MEM),
        .MemRead_MEM(MemRead_MEM),
        .MemWrite_MEM(MemWrite_MEM),
        .MemSize_MEM(MemSize_MEM),
        .MemSigned_MEM(MemSigned_MEM),
        .ReadData_MEM(ReadData_MEM),
        .Misalign_MEM(Misalign_MEM),
        .MisalignSticky(MisalignSticky)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic rd,
                                 input logic wr, input logic [1:0] size, input logic sgn);
        ALUResult_MEM = addr;
        WriteData_MEM = wdata;
        MemRead_MEM   = rd;
        MemWrite_MEM  = wr;
        MemSize_MEM   = size;
        MemSigned_MEM = sgn;
        #2;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, SZ_W, 1'b0);
        checkOutput("reset_sticky", {31'b0, MisalignSticky}, 32'h0);
        checkOutput("reset_misalign", {31'b0, Misalign_MEM}, 32'h0);
        step();
        step();
        Reset = 1'b1;
        step();

        applyStimulus(32'h10, 32'h0, 1'b0, 1'b1, SZ_W, 1'b0); step();
        applyStimulus(32'h20, 32'h01020304, 1'b0, 1'b1, SZ_W, 1'b0); step();
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, SZ_W, 1'b0); step();
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, SZ_W, 1'b0); step();

        applyStimulus(32'h10, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
        checkOutput("lw_old", ReadData_MEM, 32'h0);
        applyStimulus(32'h10, 32'hDEADBEEF, 1'b1, 1'b1, SZ_W, 1'b0);
        checkOutput("lw_during_sw", ReadData_MEM, 32'h0);
        step();
        applyStimulus(32'h10, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
        checkOutput("lw_fwd", ReadData_MEM, 32'hDEADBEEF);
        step();
        applyStimulus(32'h10, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
        checkOutput("lw_array", ReadData_MEM, 32'hDEADBEEF);

        applyStimulus(32'h13, 32'h0, 1'b1, 1'b0, SZ_B, 1'b1);
        checkOutput("lb_13", ReadData_MEM, 32'hFFFFFFDE);
        applyStimulus(32'h13, 32'h0, 1'b1, 1'b0, SZ_B, 1'b0);
        checkOutput("lbu_13", ReadData_MEM, 32'h000000DE);
        applyStimulus(32'h10, 32'h0, 1'b1, 1'b0, SZ_B, 1'b0);
        checkOutput("lbu_10", ReadData_MEM, 32'h000000EF);
        applyStimulus(32'h10, 32'h0, 1'b1, 1'b0, SZ_H, 1'b1);
        checkOutput("lh_10", ReadData_MEM, 32'hFFFFBEEF);
        applyStimulus(32'h12, 32'h0, 1'b1, 1'b0, SZ_H, 1'b0);
        checkOutput("lhu_12", ReadData_MEM, 32'h0000DEAD);
        applyStimulus(32'h10, 32'h0, 1'b0, 1'b0, SZ_W, 1'b0);
        checkOutput("read_gated", ReadData_MEM, 32'h0);
        step();

        applyStimulus(32'h10, 32'h0, 1'b0, 1'b1, SZ_W, 1'b0); step();
        applyStimulus(32'h11, 32'h00000055, 1'b0, 1'b1, SZ_B, 1'b0); step();
        applyStimulus(32'h12, 32'h00001234, 1'b0, 1'b1, SZ_H, 1'b0); step();
        applyStimulus(32'h10, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
        checkOutput("merge_fwd", ReadData_MEM, 32'h12345500);
        step();
        applyStimulus(32'h10, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
        checkOutput("merge_array", ReadData_MEM, 32'h12345500);
        step();

        applyStimulus(32'h1000, 32'hA5A5A5A5, 1'b0, 1'b1, SZ_W, 1'b0); step();
        applyStimulus(32'h0, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
        checkOutput("wrap_fwd", ReadData_MEM, 32'hA5A5A5A5);
        step();
        applyStimulus(32'h0, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
        checkOutput("wrap_array", ReadData_MEM, 32'hA5A5A5A5);
        step();

        // Store issued, then reset asserted before the edge that would commit it.
        applyStimulus(32'h20, 32'hCAFEF00D, 1'b0, 1'b1, SZ_W, 1'b0); step();
        applyStimulus(32'h20, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
        Reset = 1'b0;
        #1;
        checkOutput("rst_sticky", {31'b0, MisalignSticky}, 32'h0);
        step();
        Reset = 1'b1;
        step();
        applyStimulus(32'h20, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
        checkOutput("rst_discard", ReadData_MEM, 32'h01020304);
        step();

`ifdef DMEM_MISALIGN_TRAP_EN
        applyStimulus(32'h22, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
        checkOutput("mis_lw_flag", {31'b0, Misalign_MEM}, 32'h1);
        checkOutput("mis_lw_data", ReadData_MEM, 32'h0);
        checkOutput("mis_sticky_pre", {31'b0, MisalignSticky}, 32'h0);
        step();
        applyStimulus(32'h20, 32'h0, 1'b0, 1'b0, SZ_W, 1'b0);
        checkOutput("mis_sticky", {31'b0, MisalignSticky}, 32'h1);
        applyStimulus(32'h22, 32'hFFFFFFFF, 1'b0, 1'b1, SZ_W, 1'b0);
        checkOutput("mis_sw_flag", {31'b0, Misalign_MEM}, 32'h1);
        step();
        applyStimulus(32'h20, 32'h0, 1'b0, 1'b0, SZ_W, 1'b0); step();
        applyStimulus(32'h20, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
        checkOutput("mis_sw_blocked", ReadData_MEM, 32'h01020304);
`else
        applyStimulus(32'h22, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
        checkOutput("align_lw", ReadData_MEM, 32'h01020304);
        checkOutput("align_flag", {31'b0, Misalign_MEM}, 32'h0);
        step();
        applyStimulus(32'h23, 32'h0, 1'b1, 1'b0, SZ_H, 1'b1);
        checkOutput("align_lh", ReadData_MEM, 32'h00000102);
        checkOutput("align_sticky", {31'b0, MisalignSticky}, 32'h0);
`endif
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
